// File: rtl/fifo_byte_unpacker.sv
// fifo_byte_unpacker: pops DATA_W words from a FIFO and streams them as OUT_W beats over valid/ready
// Define UNPACK_MSB_FIRST_EN for MSB-first beat order; default is LSB-first (little-endian)
module fifo_byte_unpacker #(
  parameter int DATA_W = 32,
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_r_en,
  input  logic [DATA_W-1:0] fifo_data,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              busy
);
  localparam int N = DATA_W / OUT_W;
  localparam int IW = $clog2(N);
  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
  state_t state, next;
  logic [DATA_W-1:0] sr, sr_next;
  logic [IW-1:0] idx;
  logic done;
  always_ff @(posedge clk) state <= !rst ? IDLE : next;
  always_comb begin
    out_valid = state == SEND;
    out_last = out_valid && idx == IW'(N - 1);
    busy = state != IDLE;
    done = state == IDLE || (out_last && out_ready);
    fifo_r_en = rst && !fifo_empty && done;
    next = state == LOAD ? SEND : done ? (fifo_r_en ? LOAD : IDLE) : state;
  end
  always_comb begin
`ifdef UNPACK_MSB_FIRST_EN
    out_data = sr[DATA_W-1 -: OUT_W];
    sr_next = sr << OUT_W;
`else
    out_data = sr[OUT_W-1:0];
    sr_next = sr >> OUT_W;
`endif
  end
  always_ff @(posedge clk)
    if (!rst) begin
      sr <= '0;
      idx <= '0;
      word_cnt <= '0;
    end else if (state == LOAD) begin
      sr <= fifo_data;
      idx <= '0;
    end else if (out_valid && out_ready) begin
      sr <= sr_next;
      idx <= idx + IW'(1);
      if (out_last) word_cnt <= word_cnt + CNT_W'(1);
    end
endmodule
